// File: rtl/axp_mul_seq.sv
// Iterative integer multiplier for opcode 13 (MULL, MULQ, UMULH, MULL/V, MULQ/V).
// Retires STEP multiplier bits per cycle into a 128-bit accumulator, then fixes up the result.
module axp_mul_seq #(
   parameter int STEP  = 4,
   parameter int TAG_W = 6
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_cmd,
   input  logic [63:0]      i_a,
   input  logic [63:0]      i_b,
   input  logic [TAG_W-1:0] i_in_tag,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [63:0]      o_y,
   output logic             o_ov,
   output logic             o_ill,
   output logic [TAG_W-1:0] o_out_tag
);

   // state | meaning
   // IDLE  | waiting for an operation
   // BUSY  | accumulating STEP-bit partial products, LSB first
   // FIX   | forming y and ov from the unsigned product
   // DONE  | result presented until out_ready
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

   localparam logic [6:0] F_MULL  = 7'h00;
   localparam logic [6:0] F_MULQ  = 7'h20;
   localparam logic [6:0] F_UMULH = 7'h30;
   localparam logic [6:0] F_MULLV = 7'h40;
   localparam logic [6:0] F_MULQV = 7'h60;
   localparam logic [6:0] C_N32   = 7'(32 / STEP - 1);
   localparam logic [6:0] C_N64   = 7'(64 / STEP - 1);

   state_t             r_state;
   logic [6:0]         r_f;
   logic [63:0]        r_a;
   logic [63:0]        r_b;
   logic [63:0]        r_mplier;
   logic [127:0]       r_mcand;
   logic [127:0]       r_acc;
   logic [6:0]         r_cnt;
   logic [TAG_W-1:0]   r_tag;
   logic               r_out_valid;
   logic [63:0]        r_y;
   logic               r_ov;
   logic               r_ill;
   logic [TAG_W-1:0]   r_out_tag;

   logic [6:0]         w_f_in;
   logic               w_in_mull;
   logic               w_in_legal;
   logic               w_accept;
   logic [127:0]       w_pp;
   logic [31:0]        w_hi32;
   logic [63:0]        w_hi64;
   logic [63:0]        w_fix_y;
   logic               w_fix_ov;

   assign w_f_in     = i_cmd[11:5];
   assign w_in_mull  = (w_f_in == F_MULL) || (w_f_in == F_MULLV);
   assign w_in_legal = w_in_mull || (w_f_in == F_MULQ) || (w_f_in == F_UMULH) ||
                       (w_f_in == F_MULQV);
   assign o_in_ready = !i_flush &&
                       ((r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready));
   assign w_accept   = i_in_valid && o_in_ready;

   assign w_pp   = r_mcand * {{(128-STEP){1'b0}}, r_mplier[STEP-1:0]};
   // Signed high halves recovered from the unsigned product by subtracting the sign corrections
   assign w_hi32 = r_acc[63:32] - (r_a[31] ? r_b[31:0] : 32'd0) - (r_b[31] ? r_a[31:0] : 32'd0);
   assign w_hi64 = r_acc[127:64] - (r_a[63] ? r_b : 64'd0) - (r_b[63] ? r_a : 64'd0);

   always_comb begin
      w_fix_y  = '0;
      w_fix_ov = 1'b0;
      case (r_f)
         F_MULL:  w_fix_y = {{32{r_acc[31]}}, r_acc[31:0]};
         F_MULLV: begin
            w_fix_y  = {{32{r_acc[31]}}, r_acc[31:0]};
            w_fix_ov = (w_hi32 != {32{r_acc[31]}});
         end
         F_MULQ:  w_fix_y = r_acc[63:0];
         F_MULQV: begin
            w_fix_y  = r_acc[63:0];
            w_fix_ov = (w_hi64 != {64{r_acc[63]}});
         end
         F_UMULH: w_fix_y = r_acc[127:64];
         default: ;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_f         <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_mplier    <= '0;
         r_mcand     <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_tag       <= '0;
         r_out_valid <= 1'b0;
         r_y         <= '0;
         r_ov        <= 1'b0;
         r_ill       <= 1'b0;
         r_out_tag   <= '0;
      end else if (i_flush) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_BUSY: begin
               r_acc    <= r_acc + w_pp;
               r_mcand  <= r_mcand << STEP;
               r_mplier <= r_mplier >> STEP;
               if (r_cnt == 7'd0) r_state <= S_FIX;
               else               r_cnt   <= r_cnt - 7'd1;
            end
            S_FIX: begin
               r_y         <= w_fix_y;
               r_ov        <= w_fix_ov;
               r_ill       <= 1'b0;
               r_out_tag   <= r_tag;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: ;
         endcase
         // Accept overrides the DONE pop so a new op can start in the same cycle
         if (w_accept) begin
            r_f      <= w_f_in;
            r_a      <= i_a;
            r_b      <= i_b;
            r_tag    <= i_in_tag;
            r_acc    <= '0;
            r_mcand  <= w_in_mull ? {96'd0, i_a[31:0]} : {64'd0, i_a};
            r_mplier <= i_b;
            r_cnt    <= w_in_mull ? C_N32 : C_N64;
            if (w_in_legal) begin
               r_state <= S_BUSY;
            end else begin
               r_state     <= S_DONE;
               r_y         <= '0;
               r_ov        <= 1'b0;
               r_ill       <= 1'b1;
               r_out_tag   <= i_in_tag;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_y         = r_y;
   assign o_ov        = r_ov;
   assign o_ill       = r_ill;
   assign o_out_tag   = r_out_tag;

endmodule

// File: tb/tb_axp_mul_seq.sv
// Bench for axp_mul_seq: directed corner cases plus random ops, scoreboarded against
// a plain-arithmetic reference of the opcode 13 multiply functions.
module tb_axp_mul_seq;
   localparam int STEP  = 4;
   localparam int TAG_W = 6;

   logic             clk = 1'b0;
   logic             i_reset, i_flush, i_in_valid, i_out_ready;
   logic [31:0]      i_cmd;
   logic [63:0]      i_a, i_b;
   logic [TAG_W-1:0] i_in_tag;
   logic             o_in_ready, o_out_valid, o_ov, o_ill;
   logic [63:0]      o_y;
   logic [TAG_W-1:0] o_out_tag;

   axp_mul_seq #(.STEP(STEP), .TAG_W(TAG_W)) dut (
      .i_clock(clk), .i_reset(i_reset), .i_flush(i_flush), .i_in_valid(i_in_valid),
      .o_in_ready(o_in_ready), .i_cmd(i_cmd), .i_a(i_a), .i_b(i_b), .i_in_tag(i_in_tag),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_y(o_y), .o_ov(o_ov),
      .o_ill(o_ill), .o_out_tag(o_out_tag));

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]      y;
      logic             ov;
      logic             ill;
      logic [TAG_W-1:0] tag;
      int               lat;
      int               c_acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   fresh  = 1'b1;
   bit   rnd_rdy = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic exp_t model(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                                  input logic [TAG_W-1:0] tag);
      exp_t               e;
      logic [127:0]       pu;
      logic signed [127:0] ps;
      logic signed [63:0]  ps32;
      pu   = {64'd0, a} * {64'd0, b};
      ps   = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      ps32 = $signed({{32{a[31]}}, a[31:0]}) * $signed({{32{b[31]}}, b[31:0]});
      e.y = '0; e.ov = 1'b0; e.ill = 1'b0; e.tag = tag; e.c_acc = 0;
      e.lat = 64 / STEP + 2;
      case (f)
         7'h00: begin e.y = {{32{pu[31]}}, pu[31:0]}; e.lat = 32 / STEP + 2; end
         7'h40: begin
            e.y   = {{32{pu[31]}}, pu[31:0]};
            e.lat = 32 / STEP + 2;
            e.ov  = (ps32 > 64'sd2147483647) || (ps32 < -64'sd2147483648);
         end
         7'h20: e.y = pu[63:0];
         7'h60: begin
            e.y  = pu[63:0];
            e.ov = (ps > 128'sh7FFF_FFFF_FFFF_FFFF) || (ps < -128'sh8000_0000_0000_0000);
         end
         7'h30: e.y = pu[127:64];
         default: begin e.ill = 1'b1; e.lat = 1; end
      endcase
      return e;
   endfunction

   // Monitor: latency on first appearance of each result, contents on handshake
   always @(negedge clk) begin
      exp_t e;
      if (i_reset || i_flush) begin
         q.delete();
         fresh = 1'b1;
      end else begin
         if (o_out_valid && fresh) begin
            fresh = 1'b0;
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result: got out_valid=1 expected no pending op");
            end else begin
               chk("latency", 64'(cyc - q[0].c_acc), 64'(q[0].lat));
            end
         end
         if (o_out_valid && i_out_ready) begin
            fresh = 1'b1;
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("y", o_y, e.y);
               chk("ov", 64'(o_ov), 64'(e.ov));
               chk("ill", 64'(o_ill), 64'(e.ill));
               chk("out_tag", 64'(o_out_tag), 64'(e.tag));
            end
         end
      end
   end

   task automatic send(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                       output int waited);
      logic [31:0]      c;
      logic [TAG_W-1:0] tg;
      exp_t             e;
      c = $urandom();
      c[11:5] = f;
      tg = TAG_W'($urandom());
      i_cmd = c; i_a = a; i_b = b; i_in_tag = tg; i_in_valid = 1'b1;
      waited = 0;
      forever begin
         @(negedge clk);
         if (o_in_ready) begin
            e = model(f, a, b, tg);
            e.c_acc = cyc;
            q.push_back(e);
            break;
         end
         waited++;
         if (waited > 300) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waited);
            break;
         end
         @(posedge clk); #1;
         if (rnd_rdy) i_out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      if (rnd_rdy) i_out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic drain();
      int t;
      t = 0;
      i_out_ready = 1'b1;
      while (q.size() != 0) begin
         @(negedge clk);
         t++;
         if (t > 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic watch_none(input string name, input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (o_out_valid) seen++;
      end
      chk(name, 64'(seen), 64'd0);
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 64'hFFFF_FFFF_FFFF_FFFF;
         1: return 64'd0;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         4: return {32'($urandom()), 32'h8000_0000};
         default: return {32'($urandom()), 32'($urandom())};
      endcase
   endfunction

   initial begin
      int w;
      int t;
      logic [6:0] fl [5];
      fl[0] = 7'h00; fl[1] = 7'h20; fl[2] = 7'h30; fl[3] = 7'h40; fl[4] = 7'h60;
      i_reset = 1'b1; i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b1;
      i_cmd = '0; i_a = '0; i_b = '0; i_in_tag = '0;
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(o_out_valid), 64'd0);
      chk("rst_y", o_y, 64'd0);
      chk("rst_ov", 64'(o_ov), 64'd0);
      chk("rst_ill", 64'(o_ill), 64'd0);
      chk("rst_out_tag", 64'(o_out_tag), 64'd0);
      chk("rst_in_ready", 64'(o_in_ready), 64'd1);
      @(posedge clk); #1;

      send(7'h20, 64'd3, 64'd5, w); drain();
      send(7'h30, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, w); drain();
      send(7'h60, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, w); drain();
      send(7'h00, 64'h0000_0000_7FFF_FFFF, 64'd2, w); drain();
      send(7'h40, 64'h0000_0000_7FFF_FFFF, 64'd2, w); drain();
      send(7'h20, 64'h4000_0000_0000_0000, 64'd2, w); drain();
      send(7'h60, 64'h4000_0000_0000_0000, 64'd2, w); drain();

      // Reset mid-BUSY with a non-zero result (y=8000..., ov=1) still held
      send(7'h20, 64'h0123_4567_89AB_CDEF, 64'd77, w);
      repeat (3) @(posedge clk);
      #1 i_reset = 1'b1;
      @(posedge clk);
      #1 i_reset = 1'b0;
      @(negedge clk);
      chk("rstmid_out_valid", 64'(o_out_valid), 64'd0);
      chk("rstmid_y", o_y, 64'd0);
      chk("rstmid_ov", 64'(o_ov), 64'd0);
      chk("rstmid_out_tag", 64'(o_out_tag), 64'd0);
      @(posedge clk); #1;
      watch_none("rstmid_no_result", 25);

      // Backpressure, then pop and accept in the same cycle
      i_out_ready = 1'b0;
      send(7'h20, 64'd3, 64'd5, w);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!o_out_valid && t < 100);
      chk("bp_reached_done", 64'(o_out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(o_out_valid), 64'd1);
         chk("bp_hold_y", o_y, 64'd15);
         chk("bp_hold_ov", 64'(o_ov), 64'd0);
         chk("bp_hold_in_ready", 64'(o_in_ready), 64'd0);
      end
      @(posedge clk); #1;
      i_out_ready = 1'b1;
      send(7'h20, 64'h1234_5678, 64'h10, w);
      chk("bp_pop_accept_wait", 64'(w), 64'd0);
      drain();

      // Flush in BUSY cycle 7
      send(7'h20, pick_operand(), pick_operand(), w);
      repeat (6) @(posedge clk);
      #1 i_flush = 1'b1;
      @(posedge clk);
      #1 i_flush = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", 64'(o_in_ready), 64'd1);
      chk("flush_out_valid", 64'(o_out_valid), 64'd0);
      @(posedge clk); #1;
      watch_none("flush_no_result", 25);

      send(7'h10, pick_operand(), pick_operand(), w); drain();
      send(7'h30, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, w); drain();

      rnd_rdy = 1'b1;
      for (int n = 0; n < 150; n++) begin
         logic [6:0] f;
         f = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : fl[$urandom_range(0, 4)];
         send(f, pick_operand(), pick_operand(), w);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            i_out_ready = ($urandom_range(0, 3) != 0);
         end
      end
      rnd_rdy = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
